// File: rtl/gpio_cfg_sequencer_if.sv
// gpio_cfg_sequencer_if: table-write and serial-chain signals of gpio_cfg_sequencer.
interface gpio_cfg_sequencer_if #(
  parameter int NUM_PADS = 18
);
  localparam int AW = NUM_PADS > 1 ? $clog2(NUM_PADS) : 1;
  logic          start_i;
  logic          wr_en_i;
  logic [AW-1:0] wr_addr_i;
  logic [11:0]   wr_data_i;
  logic          wr_err_o;
  logic          busy_o;
  logic          done_o;
  logic          serial_clk_o;
  logic          serial_data_o;
  logic          serial_load_o;
  modport master (
    output start_i, wr_en_i, wr_addr_i, wr_data_i,
    input  wr_err_o, busy_o, done_o, serial_clk_o, serial_data_o, serial_load_o
  );
  modport slave (
    input  start_i, wr_en_i, wr_addr_i, wr_data_i,
    output wr_err_o, busy_o, done_o, serial_clk_o, serial_data_o, serial_load_o
  );
endinterface

// File: rtl/gpio_cfg_sequencer.sv
// gpio_cfg_sequencer: shifts the done signature and pad mode table into the pad chain, then strobes load.
module gpio_cfg_sequencer #(
  parameter int          NUM_PADS      = 18,
  parameter int          BITS_PER_PAD  = 12,
  parameter int          CLK_DIV       = 4,
  parameter logic [11:0] DEFAULT_MODE  = 12'h4C1,
  parameter logic [47:0] DONE_SEQUENCE = 48'hFEEDBADCA77E
) (
  input logic                 clk,
  input logic                 rst_n,
  gpio_cfg_sequencer_if.slave bus
);
  localparam int TOTAL_BITS = 48 + BITS_PER_PAD * NUM_PADS;
  localparam int DW = $clog2(CLK_DIV) + 1;
  localparam int BW = $clog2(TOTAL_BITS);
  localparam int AW = NUM_PADS > 1 ? $clog2(NUM_PADS) : 1;
  localparam logic [AW:0] NP = (AW + 1)'(NUM_PADS);
  typedef enum logic [1:0] {IDLE, SHIFT_LO, SHIFT_HI, LOAD} state_t;
  state_t                  state_q, state_d;
  logic [DW-1:0]           div_q, div_d;
  logic [BW-1:0]           bit_q, bit_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;
  logic [BITS_PER_PAD-1:0] tbl_q [NUM_PADS];
  logic [TOTAL_BITS-1:0]   chain;
  logic                    div_end, addr_ok, wr_ok;
  assign div_end = div_q == DW'(CLK_DIV - 1);
  assign addr_ok = {1'b0, bus.wr_addr_i} < NP;
  assign wr_ok   = bus.wr_en_i && state_q == IDLE && addr_ok;
  // The table is frozen while busy, so the chain can be indexed directly instead of preloading a shifter.
  always_comb begin
    chain = '0;
    chain[TOTAL_BITS-1 -: 48] = DONE_SEQUENCE;
    for (int i = 0; i < NUM_PADS; i++) chain[i*BITS_PER_PAD +: BITS_PER_PAD] = tbl_q[i];
  end
  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    div_d   = (state_q == IDLE || div_end) ? '0 : div_q + 1'b1;
    done_d  = state_q == LOAD && div_end;
    err_d   = bus.wr_en_i && (state_q != IDLE || !addr_ok);
    case (state_q)
      IDLE:     if (bus.start_i) begin
                  state_d = SHIFT_LO;
                  bit_d   = '0;
                end
      SHIFT_LO: state_d = div_end ? SHIFT_HI : SHIFT_LO;
      SHIFT_HI: if (div_end) begin
                  state_d = bit_q == BW'(TOTAL_BITS - 1) ? LOAD : SHIFT_LO;
                  bit_d   = bit_q == BW'(TOTAL_BITS - 1) ? bit_q : bit_q + 1'b1;
                end
      LOAD:     state_d = div_end ? IDLE : LOAD;
      default:  state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      for (int i = 0; i < NUM_PADS; i++) tbl_q[i] <= DEFAULT_MODE;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      done_q  <= done_d;
      err_q   <= err_d;
      if (wr_ok) tbl_q[bus.wr_addr_i] <= bus.wr_data_i;
    end
  end
  assign bus.busy_o        = state_q != IDLE;
  assign bus.done_o        = done_q;
  assign bus.wr_err_o      = err_q;
  assign bus.serial_clk_o  = state_q == SHIFT_HI;
  assign bus.serial_load_o = state_q == LOAD;
  assign bus.serial_data_o = (state_q == SHIFT_LO || state_q == SHIFT_HI) && chain[BW'(TOTAL_BITS - 1) - bit_q];
endmodule

// File: tb/tb_gpio_cfg_sequencer.sv
// tb_gpio_cfg_sequencer: vector table, directed corner sequences and random writes against a pad-table model.
module tb_gpio_cfg_sequencer;
  localparam int NP = 18;
  localparam int TB = 48 + 12 * NP;
  localparam int D  = 4;
  localparam int BUSY = 2 * D * TB + D;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errs = 0;
  int   checks = 0;
  logic [11:0] mdl [NP];
  gpio_cfg_sequencer_if #(.NUM_PADS(NP)) ifc ();
  gpio_cfg_sequencer #(.NUM_PADS(NP)) dut (.clk(clk), .rst_n(rst_n), .bus(ifc));
  always #5 clk = ~clk;
  typedef struct {
    logic        en;
    logic [4:0]  addr;
    logic [11:0] data;
    logic        exp_err;
  } vec_t;
  vec_t vt [7];
  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  function automatic int outs();
    return {ifc.busy_o, ifc.done_o, ifc.wr_err_o, ifc.serial_clk_o, ifc.serial_data_o, ifc.serial_load_o};
  endfunction
  function automatic void mdl_reset();
    for (int i = 0; i < NP; i++) mdl[i] = 12'h4C1;
  endfunction
  function automatic bit exp_bit(input int k);
    logic [47:0] ds = 48'hFEEDBADCA77E;
    logic [11:0] w;
    if (k < 48) return ds[47-k];
    w = mdl[NP-1-(k-48)/12];
    return w[11-(k-48)%12];
  endfunction
  task automatic write(input logic en, input logic [4:0] a, input logic [11:0] d, input logic exp);
    @(negedge clk);
    ifc.wr_en_i = en; ifc.wr_addr_i = a; ifc.wr_data_i = d;
    if (en && a < NP) mdl[a] = d;
    @(negedge clk);
    ifc.wr_en_i = 1'b0;
    check("wr_err", int'(ifc.wr_err_o), int'(exp));
    @(negedge clk);
    check("wr_err_once", int'(ifc.wr_err_o), 0);
  endtask
  task automatic run_load(input int wcyc, input int s1, input int s2, input logic sw,
                          input logic [4:0] sa, input logic [11:0] sd, input int exp_err);
    int c = 0, nbits = 0, nbad = 0, blen = 0, bfirst = -1, lfirst = -1, llen = 0, nd = 0, dcyc = -1, nerr = 0, d1 = -1;
    logic pclk = 1'b0;
    @(negedge clk);
    ifc.start_i = 1'b1;
    if (sw) begin
      ifc.wr_en_i = 1'b1; ifc.wr_addr_i = sa; ifc.wr_data_i = sd;
      if (sa < NP) mdl[sa] = sd;
    end
    while (c < BUSY + 80) begin
      @(negedge clk);
      c++;
      if (ifc.busy_o) begin blen++; if (bfirst < 0) bfirst = c; end
      if (c == 1) d1 = int'(ifc.serial_data_o);
      if (ifc.serial_clk_o && !pclk) begin
        if (nbits < TB && ifc.serial_data_o !== exp_bit(nbits)) nbad++;
        nbits++;
      end
      pclk = ifc.serial_clk_o;
      if (ifc.serial_load_o) begin if (lfirst < 0) lfirst = c; llen++; end
      if (ifc.done_o) begin if (dcyc < 0) dcyc = c; nd++; end
      if (ifc.wr_err_o) nerr++;
      ifc.start_i   = (c == s1 || c == s2);
      ifc.wr_en_i   = (c == wcyc);
      ifc.wr_addr_i = 5'd5;
      ifc.wr_data_i = 12'h006;
    end
    check("busy_first", bfirst, 1);
    check("data_cycle1", d1, int'(exp_bit(0)));
    check("bit_count", nbits, TB);
    check("bit_errors", nbad, 0);
    check("busy_len", blen, BUSY);
    check("load_first", lfirst, 1 + 2 * D * TB);
    check("load_len", llen, D);
    check("done_count", nd, 1);
    check("done_cycle", dcyc, BUSY + 1);
    check("wr_err_count", nerr, exp_err);
  endtask
  task automatic reset_mid();
    int c = 0, seen = 0;
    @(negedge clk);
    ifc.start_i = 1'b1;
    while (c < 1 + 2 * D * 100 + 2) begin
      @(negedge clk);
      c++;
      ifc.start_i = 1'b0;
      if (ifc.serial_load_o || ifc.done_o) seen++;
    end
    check("busy_before_reset", int'(ifc.busy_o), 1);
    #3 rst_n = 1'b0;
    #1 check("outs_async_reset", outs(), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    mdl_reset();
    repeat (20) begin
      @(negedge clk);
      if (ifc.serial_load_o || ifc.done_o || ifc.busy_o) seen++;
    end
    check("aborted_no_load_done", seen, 0);
  endtask
  initial begin
    vt[0] = '{1'b1, 5'd0,  12'h2C6, 1'b0};
    vt[1] = '{1'b1, 5'd17, 12'h9C2, 1'b0};
    vt[2] = '{1'b1, 5'd20, 12'hABC, 1'b1};
    vt[3] = '{1'b1, 5'd18, 12'h123, 1'b1};
    vt[4] = '{1'b1, 5'd31, 12'hFFF, 1'b1};
    vt[5] = '{1'b0, 5'd7,  12'h555, 1'b0};
    vt[6] = '{1'b1, 5'd19, 12'h0F0, 1'b1};
    ifc.start_i = 1'b0; ifc.wr_en_i = 1'b0; ifc.wr_addr_i = '0; ifc.wr_data_i = '0;
    mdl_reset();
    #1 check("outs_in_reset", outs(), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("outs_idle", outs(), 0);
    run_load(-1, -1, -1, 1'b0, 5'd0, 12'h0, 0);
    for (int i = 0; i < 7; i++) write(vt[i].en, vt[i].addr, vt[i].data, vt[i].exp_err);
    run_load(-1, -1, -1, 1'b0, 5'd0, 12'h0, 0);
    run_load(300, -1, -1, 1'b0, 5'd0, 12'h0, 1);
    run_load(-1, -1, -1, 1'b1, 5'd3, 12'hB86, 0);
    reset_mid();
    run_load(-1, 50, 1000, 1'b0, 5'd0, 12'h0, 0);
    for (int r = 0; r < 3; r++) begin
      for (int j = 0; j < 8; j++) begin
        logic [4:0]  a = 5'($urandom_range(0, 31));
        logic [11:0] d = 12'($urandom);
        write(1'b1, a, d, a >= NP);
      end
      run_load(-1, -1, -1, 1'b0, 5'd0, 12'h0, 0);
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
